// File: rtl/vga_scanout_if.sv
// Pixel-path bundle between the raster master, the pixel memory/renderer and the palette/DAC.
// The master drives addresses and aligned sync/blank/pixel outputs; pix_data returns from memory.
interface vga_scanout_if;
  logic [18:0] address;
  logic [7:0]  pix_data;
  logic [7:0]  pix_out;
  logic        hsync_n;
  logic        vsync_n;
  logic        blank_n;
  logic        vblank_start;

  modport master (
    output address,
    output pix_out,
    output hsync_n,
    output vsync_n,
    output blank_n,
    output vblank_start,
    input  pix_data
  );

  modport slave (
    input  address,
    input  pix_out,
    input  hsync_n,
    input  vsync_n,
    input  blank_n,
    input  vblank_start,
    output pix_data
  );
endinterface

// File: rtl/vga_scanout.sv
// Raster timing master: issues linear pixel addresses and re-emits the returned pixel index
// aligned with hsync/vsync/blank after the memory read latency.
module vga_scanout #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic          clk,
  input  logic          resetn,
  vga_scanout_if.master vga
);

  localparam logic [9:0] HActive    = 10'(H_ACTIVE);
  localparam logic [9:0] HSyncFirst = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncLast  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] HLast      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VActive    = 10'(V_ACTIVE);
  localparam logic [9:0] VSyncFirst = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncLast  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] VLast      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0]            h_cnt_q, v_cnt_q, h_nxt, v_nxt;
  logic [18:0]           addr_q, addr_d;
  logic                  active, hs, vs, nxt_active, frame_end;
  logic [RD_LATENCY-1:0] act_sr_q, hs_sr_q, vs_sr_q;
  logic [7:0]            pix_q;
  logic                  hsync_n_q, vsync_n_q, blank_n_q, vblank_q;

  always_comb begin
    h_nxt = h_cnt_q + 10'd1;
    v_nxt = v_cnt_q;
    if (h_cnt_q == HLast) begin
      h_nxt = '0;
      v_nxt = (v_cnt_q == VLast) ? '0 : v_cnt_q + 10'd1;
    end
  end

  assign active     = (h_cnt_q < HActive) && (v_cnt_q < VActive);
  assign hs         = (h_cnt_q >= HSyncFirst) && (h_cnt_q <= HSyncLast);
  assign vs         = (v_cnt_q >= VSyncFirst) && (v_cnt_q <= VSyncLast);
  assign nxt_active = (h_nxt < HActive) && (v_nxt < VActive);
  assign frame_end  = (h_cnt_q == HLast) && (v_cnt_q == VLast);

  // Step only when the next position is visible, so the address holds through blanking and
  // the next line picks up at y*H_ACTIVE without a multiplier.
  always_comb begin
    addr_d = addr_q;
    if (frame_end) begin
      addr_d = '0;
    end else if (nxt_active) begin
      addr_d = addr_q + 19'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      addr_q    <= '0;
      act_sr_q  <= '0;
      hs_sr_q   <= '0;
      vs_sr_q   <= '0;
      pix_q     <= '0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      blank_n_q <= 1'b0;
      vblank_q  <= 1'b0;
    end else begin
      h_cnt_q     <= h_nxt;
      v_cnt_q     <= v_nxt;
      addr_q      <= addr_d;
      act_sr_q[0] <= active;
      hs_sr_q[0]  <= hs;
      vs_sr_q[0]  <= vs;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        act_sr_q[i] <= act_sr_q[i-1];
        hs_sr_q[i]  <= hs_sr_q[i-1];
        vs_sr_q[i]  <= vs_sr_q[i-1];
      end
      // pix_data lines up with the last shift stage; blanked cycles never pass it through.
      blank_n_q <= act_sr_q[RD_LATENCY-1];
      hsync_n_q <= ~hs_sr_q[RD_LATENCY-1];
      vsync_n_q <= ~vs_sr_q[RD_LATENCY-1];
      pix_q     <= act_sr_q[RD_LATENCY-1] ? vga.pix_data : 8'h00;
      vblank_q  <= (h_cnt_q == '0) && (v_cnt_q == VActive);
    end
  end

  assign vga.address      = addr_q;
  assign vga.pix_out      = pix_q;
  assign vga.hsync_n      = hsync_n_q;
  assign vga.vsync_n      = vsync_n_q;
  assign vga.blank_n      = blank_n_q;
  assign vga.vblank_start = vblank_q;

endmodule
